// File: rtl/md_arith_control.sv
// md_arith_control: single-cycle ALU select decode plus a multi-cycle multiply/divide sequencer owning HI/LO.
// Optional feature: define MD_ARITH_DIV_EN to build the DIV/DIVU datapath and DIV state.
module md_arith_control #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [1:0]       i_alu_op,
  input  logic [5:0]       i_func,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic [3:0]       o_alu_control_c,
  output logic             o_stall_c,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_ZERO = 4'hF;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
`ifdef MD_ARITH_DIV_EN
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;
`endif
  localparam logic [5:0] FUNC_ADD   = 6'h20;
  localparam logic [5:0] FUNC_SUB   = 6'h22;
  localparam logic [5:0] FUNC_AND   = 6'h24;
  localparam logic [5:0] FUNC_OR    = 6'h25;
  localparam logic [5:0] FUNC_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef MD_ARITH_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_FIX  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_neg_q;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
`ifdef MD_ARITH_DIV_EN
  logic             r_op_div;
  logic             r_neg_r;
  logic             r_div_zero;
`endif

  logic               w_rtype;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_is_mf;
  logic               w_is_md;
  logic               w_accept;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_load_a;
  logic [WIDTH-1:0]   w_load_lo;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Instruction decode
  assign w_rtype  = i_valid & (i_alu_op == 2'd1);
  assign w_is_mul = (i_func == FUNC_MULT) | (i_func == FUNC_MULTU);
`ifdef MD_ARITH_DIV_EN
  assign w_is_div = (i_func == FUNC_DIV) | (i_func == FUNC_DIVU);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_is_mf  = (i_func == FUNC_MFHI) | (i_func == FUNC_MFLO);
  assign w_is_md  = w_is_mul | w_is_div;
  assign w_accept = w_rtype & w_is_md & (r_state == S_IDLE);
  // Even function codes are the signed variants
  assign w_signed = ~i_func[0];

  // MD ops stall until their result is written; HI/LO reads stall only while the sequencer is busy
  assign o_stall_c = ~i_reset & w_rtype & (w_is_md | (w_is_mf & r_busy));

  always_comb begin
    o_alu_control_c = ALU_ZERO;
    if (!i_reset) begin
      case (i_alu_op)
        2'd1: begin
          case (i_func)
            FUNC_ADD: o_alu_control_c = ALU_ADD;
            FUNC_SUB: o_alu_control_c = ALU_SUB;
            FUNC_AND: o_alu_control_c = ALU_AND;
            FUNC_OR:  o_alu_control_c = ALU_OR;
            FUNC_SLT: o_alu_control_c = ALU_SLT;
            default:  o_alu_control_c = ALU_ZERO;
          endcase
        end
        2'd2:    o_alu_control_c = ALU_ADD;
        2'd3:    o_alu_control_c = ALU_SUB;
        default: o_alu_control_c = ALU_ZERO;
      endcase
    end
  end

  // Operand magnitudes; divide swaps roles so r_a always holds the step operand
  assign w_mag_a = (w_signed & i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
  assign w_mag_b = (w_signed & i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;

  always_comb begin
    w_load_a  = w_mag_a;
    w_load_lo = w_mag_b;
`ifdef MD_ARITH_DIV_EN
    if (w_is_div) begin
      w_load_a  = w_mag_b;
      w_load_lo = (i_op_b == '0) ? i_op_a : w_mag_a;
    end
`endif
  end

  assign w_mul_sum = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_a} : '0);

`ifdef MD_ARITH_DIV_EN
  logic [WIDTH:0]   w_rem_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;

  // Restoring step: the partial remainder is always below the divisor, so the difference fits WIDTH bits
  assign w_rem_sh   = {r_p_hi, r_p_lo[WIDTH-1]};
  assign w_div_ge   = w_rem_sh >= {1'b0, r_a};
  assign w_div_diff = WIDTH'(w_rem_sh - {1'b0, r_a});
`endif

  // Sign correction applied during FIX
  always_comb begin
    w_prod     = {r_p_hi, r_p_lo};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo   = w_prod_fix[WIDTH-1:0];
`ifdef MD_ARITH_DIV_EN
    if (r_op_div) begin
      if (r_div_zero) begin
        w_fix_hi = r_p_lo;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = r_neg_r ? -r_p_hi : r_p_hi;
        w_fix_lo = r_neg_q ? -r_p_lo : r_p_lo;
      end
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef MD_ARITH_DIV_EN
          w_state_nxt = w_is_div ? S_DIV : S_MUL;
`else
          w_state_nxt = S_MUL;
`endif
        end
      end
      S_MUL:   if (r_count == '0) w_state_nxt = S_FIX;
`ifdef MD_ARITH_DIV_EN
      S_DIV:   if (r_count == '0) w_state_nxt = S_FIX;
`endif
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_neg_q    <= 1'b0;
      r_a        <= '0;
      r_p_hi     <= '0;
      r_p_lo     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
`ifdef MD_ARITH_DIV_EN
      r_op_div   <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_FIX);
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_count    <= CW'(WIDTH - 1);
        r_a        <= w_load_a;
        r_p_hi     <= '0;
        r_p_lo     <= w_load_lo;
        r_neg_q    <= w_signed & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
`ifdef MD_ARITH_DIV_EN
        r_op_div   <= w_is_div;
        r_neg_r    <= w_signed & i_op_a[WIDTH-1];
        r_div_zero <= (i_op_b == '0);
`endif
      end
      if (r_state == S_MUL) begin
        if (r_count != '0) r_count <= r_count - CW'(1);
        r_p_hi <= w_mul_sum[WIDTH:1];
        r_p_lo <= {w_mul_sum[0], r_p_lo[WIDTH-1:1]};
      end
`ifdef MD_ARITH_DIV_EN
      // Divide by zero keeps the raw dividend in r_p_lo for HI
      if (r_state == S_DIV) begin
        if (r_count != '0) r_count <= r_count - CW'(1);
        if (!r_div_zero) begin
          r_p_hi <= w_div_ge ? w_div_diff : w_rem_sh[WIDTH-1:0];
          r_p_lo <= {r_p_lo[WIDTH-2:0], w_div_ge};
        end
      end
`endif
      if (r_state == S_FIX) begin
        r_busy <= 1'b0;
        r_hi   <= w_fix_hi;
        r_lo   <= w_fix_lo;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_md_arith_control.sv
// tb_md_arith_control: randomized self-checking bench for md_arith_control against an arithmetic reference model.
// Divide checks follow MD_ARITH_DIV_EN; without it DIV is checked as a non-MD instruction.
module tb_md_arith_control;

  localparam int unsigned W = 32;

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_ZERO = 4'hF;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [1:0]   alu_op;
  logic [5:0]   func;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   alu_ctl;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  md_arith_control #(.WIDTH(W)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_valid         (valid),
    .i_alu_op        (alu_op),
    .i_func          (func),
    .i_op_a          (op_a),
    .i_op_b          (op_b),
    .o_alu_control_c (alu_ctl),
    .o_stall_c       (stall),
    .o_busy          (busy),
    .o_done          (done),
    .o_hi            (hi),
    .o_lo            (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_alu(input logic rst, input logic [1:0] op, input logic [5:0] f);
    if (rst) return ALU_ZERO;
    if (op == 2'd2) return ALU_ADD;
    if (op == 2'd3) return ALU_SUB;
    if (op != 2'd1) return ALU_ZERO;
    case (f)
      F_ADD:   return ALU_ADD;
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_ZERO;
    endcase
  endfunction

  // Architectural result of an MD instruction, from plain integer arithmetic
  task automatic model_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r_hi, output logic [W-1:0] r_lo);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    r_hi = '0;
    r_lo = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      F_MULT: begin
        sp = longint'(sa) * longint'(sb);
        {r_hi, r_lo} = 64'(sp);
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {r_hi, r_lo} = up;
      end
      F_DIV: begin
        if (b == '0) begin
          r_hi = a;
          r_lo = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r_hi = '0;
          r_lo = a;
        end else begin
          r_lo = W'(sa / sb);
          r_hi = W'(sa % sb);
        end
      end
      default: begin
        if (b == '0) begin
          r_hi = a;
          r_lo = '1;
        end else begin
          r_lo = a / b;
          r_hi = a % b;
        end
      end
    endcase
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] rand_nonmd_func();
    case ($urandom_range(0, 6))
      0:       return F_ADD;
      1:       return F_SUB;
      2:       return F_AND;
      3:       return F_OR;
      4:       return F_SLT;
      5:       return 6'h00;
      default: return 6'h27;
    endcase
  endfunction

  // Called at posedge+1; issues an MD op and follows it to its done cycle.
  // mode 0: hold MD instr, 1: ADD meanwhile, 2: MFLO meanwhile, 3: random non-MD meanwhile
  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    logic [1:0]   xo;
    logic [5:0]   xf;
    int           cyc;
    model_md(f, a, b, e_hi, e_lo);
    valid = 1'b1; alu_op = 2'd1; func = f; op_a = a; op_b = b;
    #1;
    check_eq("stall_accept", stall, 1'b1);
    check_eq("alu_md", alu_ctl, ALU_ZERO);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!done) begin
        check_eq("busy_run", busy, 1'b1);
        check_eq("hi_hold", hi, m_hi);
        check_eq("lo_hold", lo, m_lo);
        case (mode)
          0: check_eq("stall_hold", stall, 1'b1);
          1: begin
            alu_op = 2'd1; func = F_ADD; op_a = W'($urandom); #1;
            check_eq("alu_add_busy", alu_ctl, ALU_ADD);
            check_eq("stall_add_busy", stall, 1'b0);
          end
          2: begin
            alu_op = 2'd1; func = F_MFLO; #1;
            check_eq("stall_mflo_busy", stall, 1'b1);
          end
          default: begin
            xo = 2'($urandom_range(0, 3));
            xf = (xo == 2'd1) ? rand_nonmd_func() : 6'($urandom);
            alu_op = xo; func = xf; #1;
            check_eq("alu_other", alu_ctl, exp_alu(1'b0, xo, xf));
            check_eq("stall_other", stall, 1'b0);
          end
        endcase
      end
    end while (!done && cyc < 100);
    check_eq("latency", cyc, W + 2);
    check_eq("done_pulse", done, 1'b1);
    check_eq("busy_done", busy, 1'b0);
    check_eq("hi_result", hi, e_hi);
    check_eq("lo_result", lo, e_lo);
    if (mode == 2) check_eq("stall_mflo_done", stall, 1'b0);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  task automatic idle_cycle();
    valid = 1'b0; alu_op = 2'd0;
    @(posedge clk); #1;
    check_eq("done_cleared", done, 1'b0);
    check_eq("busy_idle", busy, 1'b0);
    check_eq("hi_idle", hi, m_hi);
    check_eq("lo_idle", lo, m_lo);
  endtask

`ifndef MD_ARITH_DIV_EN
  task automatic run_nodiv(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    valid = 1'b1; alu_op = 2'd1; func = f; op_a = a; op_b = b;
    #1;
    check_eq("nodiv_stall", stall, 1'b0);
    check_eq("nodiv_alu", alu_ctl, ALU_ZERO);
    @(posedge clk); #1;
    check_eq("nodiv_busy", busy, 1'b0);
    check_eq("nodiv_done", done, 1'b0);
    check_eq("nodiv_hi", hi, m_hi);
    check_eq("nodiv_lo", lo, m_lo);
    valid = 1'b0;
  endtask
`endif

  initial begin
    int         pulses;
    logic [5:0] rf;
    reset = 1'b1; valid = 1'b0; alu_op = 2'd0; func = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_hi", hi, '0);
    check_eq("rst_lo", lo, '0);
    valid = 1'b1; alu_op = 2'd1; func = F_MULT; #1;
    check_eq("rst_stall", stall, 1'b0);
    alu_op = 2'd2; #1;
    check_eq("rst_alu", alu_ctl, ALU_ZERO);
    reset = 1'b0;

    // First cycle out of reset accepts
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    idle_cycle();
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, 1);
    idle_cycle();
`ifdef MD_ARITH_DIV_EN
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 3);
    idle_cycle();
    run_op(F_DIVU, 32'd7, 32'd0, 0);
    idle_cycle();
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    idle_cycle();
    run_op(F_DIV, 32'hFFFF_FFF0, 32'd0, 3);
    idle_cycle();
`else
    run_nodiv(F_DIV, 32'd8, 32'd2);
    idle_cycle();
    run_nodiv(F_DIVU, 32'd9, 32'd0);
    idle_cycle();
`endif
    // MFLO waits, then a MULT issued in the done cycle is taken back to back
    run_op(F_MULT, rand_opnd(), rand_opnd(), 2);
    run_op(F_MULT, rand_opnd(), rand_opnd(), 0);
    idle_cycle();

    for (int i = 0; i < 24; i++) begin
`ifdef MD_ARITH_DIV_EN
      case ($urandom_range(0, 3))
        0:       rf = F_MULT;
        1:       rf = F_MULTU;
        2:       rf = F_DIV;
        default: rf = F_DIVU;
      endcase
`else
      rf = ($urandom_range(0, 1) == 0) ? F_MULT : F_MULTU;
`endif
      run_op(rf, rand_opnd(), rand_opnd(), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    // Reset lands on the 10th edge of a MULT (accept edge counted as the 1st)
    valid = 1'b1; alu_op = 2'd1; func = F_MULT; op_a = 32'h1234_5678; op_b = 32'h0000_0FFF;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1; valid = 1'b1; alu_op = 2'd1; func = F_MFLO; #1;
    check_eq("rst_mid_stall", stall, 1'b0);
    alu_op = 2'd3; #1;
    check_eq("rst_mid_alu", alu_ctl, ALU_ZERO);
    @(posedge clk); #1;
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_done", done, 1'b0);
    check_eq("rst_mid_hi", hi, '0);
    check_eq("rst_mid_lo", lo, '0);
    reset = 1'b0; valid = 1'b0; alu_op = 2'd0;
    m_hi = '0;
    m_lo = '0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check_eq("no_late_done", pulses, 0);
    check_eq("hi_after_rst", hi, m_hi);
    check_eq("lo_after_rst", lo, m_lo);
    run_op(F_MULTU, 32'd6, 32'd7, 3);
    idle_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
